// File: rtl/mem_refill_ctrl.sv
// rtl/mem_refill_ctrl.sv - main-memory refill controller below the L2 cache
//
// Purpose: accepts one L2 request at a time (line refill read or single-word
// write-through), models a fixed memory latency, streams refill beats back to
// L2 and drives a word-addressed, asynchronous-read memory port.
//
// Configuration macro: CRITICAL_WORD_FIRST_EN
//    defined   - read beats start at the requested word and wrap around the line
//    undefined - read beats always run 0 .. LINE_WORDS-1
//
// Ports:
//    clk, rst                     clock, synchronous active-high reset
//    req_valid/req_ready          request handshake (req_ready is combinational)
//    req_write, req_addr, req_wdata  request attributes, captured on accept
//    resp_valid, resp_data        one-cycle response beat strobe and data
//    resp_word_idx, resp_last     word index of the beat, final-beat flag
//    busy                         FSM not idle
//    mem_addr, mem_wdata, mem_we  memory port outputs (registered)
//    mem_rdata                    asynchronous memory read data
//    refill_cnt                   saturating count of completed refills

module mem_refill_ctrl #(
   parameter int LINE_WORDS  = 4,
   parameter int MEM_LATENCY = 3,
   parameter int IDX_W       = $clog2(LINE_WORDS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_data,
   output logic [IDX_W-1:0] resp_word_idx,
   output logic             resp_last,
   output logic             busy,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   output logic             mem_we,
   input  logic [31:0]      mem_rdata,
   output logic [15:0]      refill_cnt
);

   localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam int BEAT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0]  LAT_INIT = CNT_W'(MEM_LATENCY - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEATS_ALL  = BEAT_W'(LINE_WORDS);
   localparam logic [BEAT_W-1:0] BEATS_LAST = BEAT_W'(LINE_WORDS - 1);

   typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT, WR_ACK} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  lat_cnt_q;
   logic [29:0]       word_addr_q;   // captured word address (byte address >> 2)
   logic [31:0]       wdata_q;
   logic [IDX_W-1:0]  idx_q;         // word index currently presented on mem_addr
   logic [BEAT_W-1:0] beats_q;       // beats already issued in this burst
   logic              resp_valid_q;
   logic [31:0]       resp_data_q;
   logic [IDX_W-1:0]  resp_idx_q;
   logic              resp_last_q;
   logic [31:0]       mem_addr_q;
   logic [31:0]       mem_wdata_q;
   logic              mem_we_q;
   logic [15:0]       refill_cnt_q;

   logic              accept;
   logic [IDX_W-1:0]  req_first_idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic [31:0]       next_beat_addr;
   logic [15:0]       refill_cnt_d;

   assign req_ready = (state_q == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

`ifdef CRITICAL_WORD_FIRST_EN
   assign req_first_idx = req_addr[IDX_W+1:2];
`else
   assign req_first_idx = '0;
`endif

   assign idx_nxt        = idx_q + IDX_ONE;   // wraps modulo LINE_WORDS
   assign next_beat_addr = {word_addr_q[29:IDX_W], idx_nxt, 2'b00};
   assign refill_cnt_d   = (refill_cnt_q == 16'hFFFF) ? refill_cnt_q : refill_cnt_q + 16'd1;

   // The memory address is presented one cycle ahead of each beat so that the
   // registered resp_data samples the asynchronous read of the matching word.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         lat_cnt_q    <= '0;
         word_addr_q  <= '0;
         wdata_q      <= '0;
         idx_q        <= '0;
         beats_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_data_q  <= '0;
         resp_idx_q   <= '0;
         resp_last_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_we_q     <= 1'b0;
         refill_cnt_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               resp_valid_q <= 1'b0;
               resp_last_q  <= 1'b0;
               if (accept) begin
                  word_addr_q <= req_addr[31:2];
                  wdata_q     <= req_wdata;
                  lat_cnt_q   <= LAT_INIT;
                  if (req_write) begin
                     state_q     <= WR_WAIT;
                     mem_addr_q  <= req_addr & ~32'h3;
                     mem_wdata_q <= req_wdata;
                     mem_we_q    <= (MEM_LATENCY == 1);
                  end else begin
                     state_q    <= RD_WAIT;
                     idx_q      <= req_first_idx;
                     mem_addr_q <= {req_addr[31:IDX_W+2], req_first_idx, 2'b00};
                  end
               end
            end
            RD_WAIT: begin
               if (lat_cnt_q == '0) begin
                  state_q      <= RD_BURST;
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= mem_rdata;
                  resp_idx_q   <= idx_q;
                  resp_last_q  <= 1'b0;
                  beats_q      <= BEAT_ONE;
                  idx_q        <= idx_nxt;
                  mem_addr_q   <= next_beat_addr;
               end else begin
                  lat_cnt_q <= lat_cnt_q - CNT_ONE;
               end
            end
            RD_BURST: begin
               if (beats_q == BEATS_ALL) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_last_q  <= 1'b0;
                  refill_cnt_q <= refill_cnt_d;
               end else begin
                  resp_valid_q <= 1'b1;
                  resp_data_q  <= mem_rdata;
                  resp_idx_q   <= idx_q;
                  resp_last_q  <= (beats_q == BEATS_LAST);
                  beats_q      <= beats_q + BEAT_ONE;
                  idx_q        <= idx_nxt;
                  // Hold the address on the final beat instead of wrapping back.
                  if (beats_q != BEATS_LAST) begin
                     mem_addr_q <= next_beat_addr;
                  end
               end
            end
            WR_WAIT: begin
               if (lat_cnt_q == '0) begin
                  state_q      <= WR_ACK;
                  mem_we_q     <= 1'b0;
                  resp_valid_q <= 1'b1;
                  resp_last_q  <= 1'b1;
                  resp_data_q  <= wdata_q;
                  resp_idx_q   <= word_addr_q[IDX_W-1:0];
               end else begin
                  lat_cnt_q <= lat_cnt_q - CNT_ONE;
                  mem_we_q  <= (lat_cnt_q == CNT_ONE);
               end
            end
            WR_ACK: begin
               state_q      <= IDLE;
               resp_valid_q <= 1'b0;
               resp_last_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy          = (state_q != IDLE);
   assign resp_valid    = resp_valid_q;
   assign resp_data     = resp_data_q;
   assign resp_word_idx = resp_idx_q;
   assign resp_last     = resp_last_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_we        = mem_we_q;
   assign refill_cnt    = refill_cnt_q;

endmodule

// File: tb/tb_mem_refill_ctrl.sv
// tb/tb_mem_refill_ctrl.sv - directed self-checking bench for mem_refill_ctrl

module tb_mem_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic [1:0]  resp_word_idx;
   logic        resp_last;
   logic        busy;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic [31:0] mem_rdata;
   logic [15:0] refill_cnt;

   int checks = 0;
   int fails  = 0;
   int exp_refill = 0;

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the word address.
   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   assign mem_rdata = mem_fn(mem_addr);

   mem_refill_ctrl #(.LINE_WORDS(4), .MEM_LATENCY(3)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_data(resp_data), .resp_word_idx(resp_word_idx),
      .resp_last(resp_last), .busy(busy),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
      .refill_cnt(refill_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_data"}, resp_data, 0);
      chk({tag, "_resp_idx"}, resp_word_idx, 0);
      chk({tag, "_resp_last"}, resp_last, 0);
      chk({tag, "_mem_we"}, mem_we, 0);
      chk({tag, "_mem_addr"}, mem_addr, 0);
      chk({tag, "_mem_wdata"}, mem_wdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_refill"}, refill_cnt, 0);
      chk({tag, "_ready"}, req_ready, 0);
   endtask

   // Present a request at the current negedge; returns at the negedge after the accept edge.
   task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d);
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Checks a full read from the cycle after accept through the IDLE gap cycle.
   task automatic read_body(input logic [31:0] addr);
      logic [1:0]  first;
      logic [1:0]  ix;
      logic [1:0]  ixn;
      logic [31:0] a;
`ifdef CRITICAL_WORD_FIRST_EN
      first = addr[3:2];
`else
      first = 2'd0;
`endif
      chk("rd_busy", busy, 1);
      chk("rd_ready_low", req_ready, 0);
      chk("rd_addr_first", mem_addr, {addr[31:4], first, 2'b00});
      chk("rd_no_beat_c1", resp_valid, 0);
      @(negedge clk);
      chk("rd_no_beat_c2", resp_valid, 0);
      @(negedge clk);
      chk("rd_no_beat_c3", resp_valid, 0);
      chk("rd_no_we", mem_we, 0);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         ix = first + 2'(k);
         a  = {addr[31:4], ix, 2'b00};
         chk("rd_beat_valid", resp_valid, 1);
         chk("rd_beat_idx", resp_word_idx, ix);
         chk("rd_beat_data", resp_data, mem_fn(a));
         chk("rd_beat_last", resp_last, (k == 3) ? 1 : 0);
         chk("rd_beat_busy", busy, 1);
         if (k < 3) begin
            ixn = first + 2'(k + 1);
            chk("rd_next_addr", mem_addr, {addr[31:4], ixn, 2'b00});
         end
      end
      @(negedge clk);
      exp_refill++;
      chk("rd_end_valid", resp_valid, 0);
      chk("rd_end_busy", busy, 0);
      chk("rd_end_ready", req_ready, 1);
      chk("rd_end_refill", refill_cnt, 32'(exp_refill));
   endtask

   // Checks a write from the cycle after accept through the return to IDLE.
   task automatic write_body(input logic [31:0] addr, input logic [31:0] d);
      chk("wr_busy", busy, 1);
      chk("wr_we_c1", mem_we, 0);
      chk("wr_addr", mem_addr, addr & ~32'h3);
      chk("wr_wdata", mem_wdata, d);
      @(negedge clk);
      chk("wr_we_c2", mem_we, 0);
      @(negedge clk);
      chk("wr_we_pulse", mem_we, 1);
      chk("wr_we_addr", mem_addr, addr & ~32'h3);
      chk("wr_we_wdata", mem_wdata, d);
      chk("wr_no_ack_yet", resp_valid, 0);
      @(negedge clk);
      chk("wr_we_off", mem_we, 0);
      chk("wr_ack_valid", resp_valid, 1);
      chk("wr_ack_last", resp_last, 1);
      chk("wr_ack_data", resp_data, d);
      chk("wr_ack_idx", resp_word_idx, addr[3:2]);
      @(negedge clk);
      chk("wr_end_valid", resp_valid, 0);
      chk("wr_end_busy", busy, 0);
      chk("wr_refill_same", refill_cnt, 32'(exp_refill));
   endtask

   initial begin
      // Reset held for two edges with a request pending.
      rst       = 1'b1;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 32'h0000_0048;
      req_wdata = 32'h0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk_reset_state("rst");
      rst       = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("rst_release_ready", req_ready, 1);
      @(negedge clk);

      // Refill read at 0x48.
      start_req(1'b0, 32'h0000_0048, 32'h0);
      req_valid = 1'b0;
      read_body(32'h0000_0048);

      // Write-through.
      start_req(1'b1, 32'h0000_0107, 32'hDEAD_BEEF);
      req_valid = 1'b0;
      write_body(32'h0000_0107, 32'hDEAD_BEEF);

      // Read at a different start word.
      start_req(1'b0, 32'h0000_1234, 32'h0);
      req_valid = 1'b0;
      read_body(32'h0000_1234);

      // Back-to-back: read accepted, write then held on req_valid while busy.
      start_req(1'b0, 32'h0000_0048, 32'h0);
      req_write = 1'b1;
      req_addr  = 32'h0000_0200;
      req_wdata = 32'h1234_5678;
      read_body(32'h0000_0048);
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      write_body(32'h0000_0200, 32'h1234_5678);

      // Abort during the second read beat.
      start_req(1'b0, 32'h0000_0048, 32'h0);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      chk("abort_beat0", resp_valid, 1);
      @(negedge clk);
      chk("abort_beat1", resp_valid, 1);
      rst = 1'b1;
      @(negedge clk);
      exp_refill = 0;
      chk_reset_state("abort");
      rst = 1'b0;
      @(negedge clk);
      chk("abort_no_beat", resp_valid, 0);
      chk("abort_idle", busy, 0);
      chk("abort_refill", refill_cnt, 0);
      start_req(1'b0, 32'h0000_0048, 32'h0);
      req_valid = 1'b0;
      read_body(32'h0000_0048);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
